// File: rtl/tanh_deriv_bwd_4bit_stream_pkg.sv
// rtl/tanh_deriv_bwd_4bit_stream_pkg.sv - shared constants, types and helpers for the tanh backward block
//
// Purpose: Q0.4 fixed-point constants used by the tanh-derivative pipeline,
//          the stage-1 payload struct, and the arithmetic helpers that build
//          the derivative table and round the product back to Q0.4.
package tanh_bwd_pkg;

  localparam int Q_W    = 4;        // Q0.4 magnitude width
  localparam int P_W    = 2 * Q_W;  // full product width of two Q0.4 values
  localparam int ONE_SQ = 256;      // 1.0 squared, expressed in Q0.8
  localparam int RND    = 8;        // half an LSB of Q0.4 in Q0.8, round-half-up
  localparam int D_MAX  = 15;       // largest derivative representable in Q0.4

  // Stage-1 payload: derivative looked up from Y, the gradient, its sign.
  typedef struct packed {
    logic [Q_W-1:0] d;
    logic [Q_W-1:0] g;
    logic           sign;
  } s1_t;

  // 1 - Y^2 in Q0.4, truncated; Y=0 gives exactly 1.0 which is clamped to 15/16.
  function automatic logic [Q_W-1:0] deriv_d(input int y);
    int v;
    v = (ONE_SQ - y * y) >> Q_W;
    if (v > D_MAX) v = D_MAX;
    return Q_W'(v);
  endfunction

  // Q0.8 product back to Q0.4 with round-half-up. Max input is 15*15=225,
  // so the +8 never carries out of P_W bits.
  function automatic logic [Q_W-1:0] round_q04(input logic [P_W-1:0] p);
    logic [P_W-1:0] r;
    r = p + P_W'(RND);
    return r[P_W-1:Q_W];
  endfunction

endpackage

// File: rtl/tanh_deriv_bwd_4bit_stream_if.sv
// rtl/tanh_deriv_bwd_4bit_stream_if.sv - input/output stream bundle of the tanh backward block
//
// Purpose: groups the Y/G/sign input stream and the result output stream.
//   in_valid/in_ready  input handshake
//   in_y, in_g         Q0.4 tanh output and gradient magnitudes
//   in_sign            gradient sign
//   out_valid/out_ready output handshake
//   out_g, out_sign    result magnitude and sign
// master = producer of inputs / consumer of results; slave = the block itself.
interface tanh_deriv_bwd_4bit_stream_if;
  import tanh_bwd_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [Q_W-1:0] in_y;
  logic [Q_W-1:0] in_g;
  logic           in_sign;
  logic           out_valid;
  logic           out_ready;
  logic [Q_W-1:0] out_g;
  logic           out_sign;

  modport master (
    output in_valid, in_y, in_g, in_sign, out_ready,
    input  in_ready, out_valid, out_g, out_sign
  );

  modport slave (
    input  in_valid, in_y, in_g, in_sign, out_ready,
    output in_ready, out_valid, out_g, out_sign
  );

endinterface

// File: rtl/tanh_deriv_bwd_4bit_stream_lut.sv
// rtl/tanh_deriv_bwd_4bit_stream_lut.sv - combinational 16-entry Y -> (1 - Y^2) table
//
// Purpose: maps a Q0.4 tanh output Y to D = min(15, floor((256 - Y*Y)/16)).
// Ports:
//   y  in  Q_W  tanh output magnitude, Q0.4
//   d  out Q_W  derivative 1 - Y^2, Q0.4
module tanh_deriv_lut
  import tanh_bwd_pkg::*;
(
  input  logic [Q_W-1:0] y,
  output logic [Q_W-1:0] d
);

  // Table contents are elaboration-time constants; only the read mux is logic.
  logic [Q_W-1:0] table_q [1<<Q_W];

  always_comb begin
    for (int i = 0; i < (1 << Q_W); i++) begin
      table_q[i] = deriv_d(i);
    end
    d = table_q[y];
  end

endmodule

// File: rtl/tanh_deriv_bwd_4bit_stream.sv
// rtl/tanh_deriv_bwd_4bit_stream.sv - 2-stage streaming G*(1-Y^2) backward pass for 4-bit tanh
//
// Purpose: computes out_g = round(G * (1 - Y^2)) in Q0.4 with a valid/ready
//          pipeline (stage 1: derivative lookup, stage 2: multiply/round) and
//          counts non-zero gradients that quantise to zero.
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous active-high reset
//   bus       slave       input stream (in_*) and result stream (out_*)
//   zero_cnt  out  CNT_W  saturating count of results with in_g!=0, out_g==0
//   cnt_clr   in   1      synchronous clear of zero_cnt, beats an increment
module tanh_deriv_bwd_4bit_stream
  import tanh_bwd_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  tanh_deriv_bwd_4bit_stream_if.slave  bus,
  output logic [CNT_W-1:0]             zero_cnt,
  input  logic                         cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic           s1_valid;
  s1_t            s1;
  logic           s2_zero;
  logic [Q_W-1:0] lut_d;
  logic           s2_can_accept;
  logic           out_fire;
  logic [Q_W-1:0] s2_res;
  logic           s2_res_zero;

  tanh_deriv_lut u_lut (
    .y (bus.in_y),
    .d (lut_d)
  );

  // Stage 2 is free when empty or draining this cycle; stage 1 likewise,
  // which lets bubbles collapse and keeps one result per cycle.
  assign s2_can_accept = !bus.out_valid || bus.out_ready;
  assign bus.in_ready  = !s1_valid || s2_can_accept;
  assign out_fire      = bus.out_valid && bus.out_ready;

  assign s2_res      = round_q04(P_W'(s1.g) * P_W'(s1.d));
  assign s2_res_zero = (s1.g != '0) && (s2_res == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1            <= '0;
      bus.out_valid <= 1'b0;
      bus.out_g     <= '0;
      bus.out_sign  <= 1'b0;
      s2_zero       <= 1'b0;
    end else begin
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1.d    <= lut_d;
          s1.g    <= bus.in_g;
          s1.sign <= bus.in_sign;
        end
      end
      // Result registers only move when stage 2 is free, so they hold
      // steady through a downstream stall.
      if (s2_can_accept) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_g    <= s2_res;
          bus.out_sign <= s1.sign;
          s2_zero      <= s2_res_zero;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      zero_cnt <= '0;
    end else if (out_fire && s2_zero && (zero_cnt != CNT_MAX)) begin
      zero_cnt <= zero_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tanh_deriv_bwd_4bit_stream.sv
// tb/tb_tanh_deriv_bwd_4bit_stream.sv - scoreboard bench for the tanh backward stream block
module tb_tanh_deriv_bwd_4bit_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cnt_clr = 1'b0;
  logic [15:0] zero_cnt;
  logic [1:0]  zero_cnt2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int g;
    int sign;
    int zero;
  } exp_t;

  exp_t q[$];
  int   mcnt  = 0;
  int   mcnt2 = 0;
  logic prev_stall = 1'b0;

  tanh_deriv_bwd_4bit_stream_if bus ();
  tanh_deriv_bwd_4bit_stream_if bus2 ();

  // Second instance with a 2-bit counter sees the identical stream.
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_y      = bus.in_y;
  assign bus2.in_g      = bus.in_g;
  assign bus2.in_sign   = bus.in_sign;
  assign bus2.out_ready = bus.out_ready;

  tanh_deriv_bwd_4bit_stream #(.CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .zero_cnt (zero_cnt),
    .cnt_clr  (cnt_clr)
  );

  tanh_deriv_bwd_4bit_stream #(.CNT_W(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus2),
    .zero_cnt (zero_cnt2),
    .cnt_clr  (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // G * (1 - Y^2) with Y, G as fractions of 16, result rounded to sixteenths.
  function automatic int ref_g(input int y, input int g);
    int d;
    d = (256 - y * y) / 16;
    if (d > 15) d = 15;
    return (g * d + 8) / 16;
  endfunction

  // Scoreboard: checks the presented result against the oldest expectation,
  // tracks counter expectations, and records newly accepted inputs.
  always @(negedge clk) begin
    exp_t e;
    int   z;
    chk("in_ready", int'(bus.in_ready), int'(!(q.size() == 2 && !bus.out_ready)));
    chk("zero_cnt", int'(zero_cnt), mcnt);
    chk("zero_cnt_w2", int'(zero_cnt2), mcnt2);
    if (prev_stall) chk("stall_hold_valid", int'(bus.out_valid), 1);
    if (bus.out_valid) begin
      chk("out_pending", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        chk("out_g", int'(bus.out_g), q[0].g);
        chk("out_sign", int'(bus.out_sign), q[0].sign);
      end
    end
    if (rst) begin
      q.delete();
      mcnt       = 0;
      mcnt2      = 0;
      prev_stall = 1'b0;
    end else begin
      z = 0;
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        e = q.pop_front();
        z = e.zero;
      end
      if (cnt_clr) begin
        mcnt  = 0;
        mcnt2 = 0;
      end else if (z != 0) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt2 < 3) mcnt2++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      if (bus.in_valid && bus.in_ready) begin
        e.g    = ref_g(int'(bus.in_y), int'(bus.in_g));
        e.sign = int'(bus.in_sign);
        e.zero = int'(bus.in_g != 0 && e.g == 0);
        q.push_back(e);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one pair until accepted; rnd_ready re-rolls out_ready each cycle.
  task automatic send(input int y, input int g, input int s, input bit rnd_ready);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_y     = y[3:0];
    bus.in_g     = g[3:0];
    bus.in_sign  = s[0];
    while (!acc && n < 200) begin
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = bus.in_ready;
      cycle();
      n++;
    end
    bus.in_valid = 1'b0;
    chk("send_accept", int'(acc), 1);
  endtask

  // Pipeline must be empty with out_ready high; checks the 2-cycle latency.
  task automatic send_lat(input int y, input int g, input int s, input int exp_g);
    bus.out_ready = 1'b1;
    send(y, g, s, 1'b0);
    chk("lat_not_yet", int'(bus.out_valid), 0);
    cycle();
    chk("lat_valid", int'(bus.out_valid), 1);
    chk("lat_out_g", int'(bus.out_g), exp_g);
    chk("lat_out_sign", int'(bus.out_sign), s);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((q.size() != 0 || bus.out_valid) && n < 50) begin
      cycle();
      n++;
    end
    cycle();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ys[8];
    int gs[8];
    int c;
    int k;
    int n;
    logic acc;
    logic saw_full;

    bus.in_valid  = 1'b0;
    bus.in_y      = '0;
    bus.in_g      = '0;
    bus.in_sign   = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_g", int'(bus.out_g), 0);
    chk("rst_out_sign", int'(bus.out_sign), 0);
    chk("rst_zero_cnt", int'(zero_cnt), 0);

    // Directed arithmetic and latency.
    send_lat(8, 15, 1, 11);
    send_lat(0, 15, 0, 14);
    send_lat(15, 7, 1, 0);
    send_lat(15, 0, 0, 0);
    drain();
    chk("zero_cnt_after_directed", int'(zero_cnt), 1);

    // Back-to-back 8 pairs with a downstream stall in cycles 3..7.
    for (int i = 0; i < 8; i++) begin
      ys[i] = $urandom_range(0, 15);
      gs[i] = $urandom_range(0, 15);
    end
    c = 0;
    k = 0;
    saw_full = 1'b0;
    while ((k < 8 || c <= 8) && c < 100) begin
      bus.out_ready = !(c >= 3 && c <= 7);
      bus.in_valid  = (k < 8);
      if (k < 8) begin
        bus.in_y    = ys[k][3:0];
        bus.in_g    = gs[k][3:0];
        bus.in_sign = k[0];
      end
      #1;
      acc = bus.in_valid && bus.in_ready;
      if (!bus.in_ready) saw_full = 1'b1;
      cycle();
      if (acc) k++;
      c++;
    end
    chk("stream_all_accepted", k, 8);
    chk("stream_in_ready_dropped", int'(saw_full), 1);
    drain();

    // Saturation of the 2-bit counter, then clear racing an increment.
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(15, 7, 0, 1'b0);
    drain();
    chk("w2_saturated", int'(zero_cnt2), 3);
    bus.out_ready = 1'b0;
    send(15, 7, 1, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      cycle();
      n++;
    end
    chk("clr_race_ready", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    chk("clr_wins_main", int'(zero_cnt), 0);
    chk("clr_wins_w2", int'(zero_cnt2), 0);
    drain();

    // Exhaustive Y,G sweep with random backpressure and idle gaps.
    for (int y = 0; y < 16; y++) begin
      for (int g = 0; g < 16; g++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          cycle();
        end
        send(y, g, int'($urandom_range(0, 1)), 1'b1);
      end
    end
    drain();

    // Reset with two pairs in flight.
    bus.out_ready = 1'b0;
    send(3, 9, 1, 1'b0);
    send(15, 5, 0, 1'b0);
    rst = 1'b1;
    cycle();
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_zero_cnt", int'(zero_cnt), 0);
    rst = 1'b0;
    send_lat(8, 15, 1, 11);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
